// File: rtl/traffic_light_pkg.sv
// Shared types and defaults for the two-street traffic light controller.
// Holds the phase enum, parameter defaults and the phase-timer width helper.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      S_GA   = 3'd0,
      S_YA   = 3'd1,
      S_GB   = 3'd2,
      S_YB   = 3'd3,
      S_EMER = 3'd4
   } state_t;

   localparam int MIN_GREEN_DEF = 4;
   localparam int MAX_GREEN_DEF = 8;
   localparam int YELLOW_DEF    = 2;
   localparam int ALL_RED_DEF   = 2;

   function automatic int timer_width(
      input int a,
      input int b,
      input int c,
      input int d
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (m < 1) m = 1;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: cleared on phase change, saturates at all-ones.
// Saturation keeps long greens from wrapping back below the thresholds.
module tlc_phase_timer
   import traffic_light_pkg::*;
#(
   parameter int W = timer_width(MIN_GREEN_DEF, MAX_GREEN_DEF,
                                 YELLOW_DEF, ALL_RED_DEF)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CMAX = '1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != CMAX) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_controller.sv
// Moore controller for a two-street intersection with sensor-driven greens.
// Emergency forces all-red; service then restarts on street A.
module traffic_light_controller
   import traffic_light_pkg::*;
#(
   parameter int MIN_GREEN_CYCLES = MIN_GREEN_DEF,
   parameter int MAX_GREEN_CYCLES = MAX_GREEN_DEF,
   parameter int YELLOW_CYCLES    = YELLOW_DEF,
   parameter int ALL_RED_CYCLES   = ALL_RED_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic Sa,
   input  logic Sb,
   input  logic emergency,
   output logic Ra,
   output logic Ya,
   output logic Ga,
   output logic Rb,
   output logic Yb,
   output logic Gb
);

   localparam int TW = timer_width(MIN_GREEN_CYCLES, MAX_GREEN_CYCLES,
                                   YELLOW_CYCLES, ALL_RED_CYCLES);

   localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN_CYCLES - 1);
   localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN_CYCLES - 1);
   localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYCLES - 1);
   localparam logic [TW-1:0] T_ALL = TW'(ALL_RED_CYCLES - 1);

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   timer;
   logic            timer_clear;

   // Holding emergency high keeps the all-red timer pinned at zero.
   assign timer_clear = emergency | (state_d != state_q);

   tlc_phase_timer #(
      .W (TW)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .count (timer)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_GA;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (emergency) begin
         state_d = S_EMER;
      end else begin
         case (state_q)
            S_GA: begin
               if (timer >= T_MIN &&
                   (!Sa || (Sb && timer >= T_MAX)))
                  state_d = S_YA;
            end
            S_YA: begin
               if (timer == T_YEL) state_d = S_GB;
            end
            S_GB: begin
               if (timer >= T_MIN &&
                   (!Sb || (Sa && timer >= T_MAX)))
                  state_d = S_YB;
            end
            S_YB: begin
               if (timer == T_YEL) state_d = S_GA;
            end
            S_EMER: begin
               if (timer == T_ALL) state_d = S_GA;
            end
            default: state_d = S_GA;
         endcase
      end
   end

   always_comb begin
      Ra = 1'b0;
      Ya = 1'b0;
      Ga = 1'b0;
      Rb = 1'b0;
      Yb = 1'b0;
      Gb = 1'b0;
      case (state_q)
         S_GA: begin
            Ga = 1'b1;
            Rb = 1'b1;
         end
         S_YA: begin
            Ya = 1'b1;
            Rb = 1'b1;
         end
         S_GB: begin
            Ra = 1'b1;
            Gb = 1'b1;
         end
         S_YB: begin
            Ra = 1'b1;
            Yb = 1'b1;
         end
         default: begin
            Ra = 1'b1;
            Rb = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller.
// Lamps are compared as {Ra,Ya,Ga,Rb,Yb,Gb}.
module tb_traffic_light_controller;

   logic clk;
   logic reset;
   logic Sa;
   logic Sb;
   logic emergency;
   logic Ra, Ya, Ga, Rb, Yb, Gb;
   logic [5:0] lamps;

   int n_tests;
   int n_fail;

   localparam logic [5:0] L_GA = 6'b001_100;
   localparam logic [5:0] L_YA = 6'b010_100;
   localparam logic [5:0] L_GB = 6'b100_001;
   localparam logic [5:0] L_YB = 6'b100_010;
   localparam logic [5:0] L_EM = 6'b100_100;

   traffic_light_controller dut (
      .clk       (clk),
      .reset     (reset),
      .Sa        (Sa),
      .Sb        (Sb),
      .emergency (emergency),
      .Ra        (Ra),
      .Ya        (Ya),
      .Ga        (Ga),
      .Rb        (Rb),
      .Yb        (Yb),
      .Gb        (Gb)
   );

   assign lamps = {Ra, Ya, Ga, Rb, Yb, Gb};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string      tag,
      input logic [5:0] obs,
      input logic [5:0] exp
   );
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset is applied and released 1 time unit after an edge,
   // so the cycle after release is phase-cycle 0.
   task automatic do_reset(input logic sa, input logic sb);
      reset = 1'b1;
      Sa = sa;
      Sb = sb;
      emergency = 1'b0;
      #1;
      check("reset_lamps", lamps, L_GA);
      step();
      reset = 1'b0;
   endtask

   // Free-running alternation with green length g: g GA, 2 YA, g GB, 2 YB.
   function automatic logic [5:0] alt_exp(input int k, input int g);
      int p;
      p = k % (2 * g + 4);
      if (p < g)             return L_GA;
      else if (p < g + 2)    return L_YA;
      else if (p < 2 * g + 2) return L_GB;
      else                   return L_YB;
   endfunction

   initial begin
      n_tests = 0;
      n_fail = 0;
      reset = 1'b1;
      Sa = 1'b0;
      Sb = 1'b0;
      emergency = 1'b0;
      #2;

      // No cars: 4/2/4/2 alternation
      do_reset(1'b0, 1'b0);
      check("t1_k0", lamps, L_GA);
      for (int k = 1; k <= 24; k++) begin
         step();
         check($sformatf("t1_k%0d", k), lamps, alt_exp(k, 4));
      end

      // Only A: green held
      do_reset(1'b1, 1'b0);
      check("t2_k0", lamps, L_GA);
      for (int k = 1; k <= 30; k++) begin
         step();
         check($sformatf("t2_k%0d", k), lamps, L_GA);
      end

      // Both: 8/2/8/2 alternation
      do_reset(1'b1, 1'b1);
      check("t3_k0", lamps, L_GA);
      for (int k = 1; k <= 40; k++) begin
         step();
         check($sformatf("t3_k%0d", k), lamps, alt_exp(k, 8));
      end

      // Only B: GB held past timer saturation, then Sb drops
      do_reset(1'b0, 1'b1);
      check("t4_k0", lamps, L_GA);
      for (int k = 1; k <= 29; k++) begin
         step();
         if (k <= 3)       check($sformatf("t4_k%0d", k), lamps, L_GA);
         else if (k <= 5)  check($sformatf("t4_k%0d", k), lamps, L_YA);
         else if (k <= 22) check($sformatf("t4_k%0d", k), lamps, L_GB);
         else if (k <= 24) check($sformatf("t4_k%0d", k), lamps, L_YB);
         else if (k <= 28) check($sformatf("t4_k%0d", k), lamps, L_GA);
         else              check($sformatf("t4_k%0d", k), lamps, L_YA);
         if (k == 22) Sb = 1'b0;
      end

      // Emergency raised during GB cycle 2, high for 5 edges
      do_reset(1'b0, 1'b0);
      for (int k = 1; k <= 19; k++) begin
         step();
         if (k <= 8)       check($sformatf("t5_k%0d", k), lamps, alt_exp(k, 4));
         else if (k <= 14) check($sformatf("t5_k%0d", k), lamps, L_EM);
         else if (k <= 18) check($sformatf("t5_k%0d", k), lamps, L_GA);
         else              check($sformatf("t5_k%0d", k), lamps, L_YA);
         if (k == 8)  emergency = 1'b1;
         if (k == 13) emergency = 1'b0;
      end

      // Async reset in the middle of YB
      do_reset(1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) step();
      check("t6_yb", lamps, L_YB);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async", lamps, L_GA);
      step();
      reset = 1'b0;
      check("t6_k0", lamps, L_GA);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("t6_k%0d", k), lamps, (k <= 3) ? L_GA : L_YA);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
